io_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's IO port, downstream of the MMU's IO window. It decodes the MMU's byte-addressed IO bus (`io_addr`, `io_en`, `io_we`, `io_data_write`, `io_data_read`) and buffers written bytes in a small FIFO. It serialises them as 8N1 frames on `tx` with a programmable baud divisor, giving firmware a polled console without stalling the pipeline.

---
 rtl/io_uart_tx_if.sv | 19 +
 rtl/io_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_io_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_uart_tx_if.sv
// IO-window bus between the MMU (master) and the UART transmitter (slave).
// Byte address, access strobe, write qualifier and 32-bit data in both directions.
interface io_uart_tx_if;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  modport master (
    output io_addr, io_en, io_we, io_data_write,
    input  io_data_read
  );

  modport slave (
    input  io_addr, io_en, io_we, io_data_write,
    output io_data_read
  );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers, a small
// TX FIFO and a serialiser with a programmable bit period.
module io_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic         clk,
  input  logic         reset,
  io_uart_tx_if.slave  io,
  output logic         tx,
  output logic         tx_idle
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      div_q, div_d;
  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [5:0]  word;
  logic        wr_en, push_req, push_ok, status_wr, div_wr, pop;
  logic        fifo_full, fifo_empty;
  logic [15:0] reload;
  logic        unused_bits;

  assign word       = io.io_addr[7:2];
  assign wr_en      = io.io_en & io.io_we;
  assign push_req   = wr_en && (word == 6'd0);
  assign status_wr  = wr_en && (word == 6'd1);
  assign div_wr     = wr_en && (word == 6'd2);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
  assign push_ok    = push_req && !fifo_full;
  // A divisor of zero is treated as a one-cycle bit period.
  assign reload     = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign unused_bits = ^{io.io_addr[1:0], io.io_data_write[31:16]};

  // Register file and FIFO bookkeeping.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    div_d      = div_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (status_wr && io.io_data_write[3]) overflow_d = 1'b0;
    if (push_req && fifo_full)            overflow_d = 1'b1;
    if (div_wr)                           div_d      = io.io_data_write[15:0];
  end

  // Serialiser: each state lasts reload+1 cycles; the period is resampled at every bit boundary.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = reload;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          baud_d    = reload;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d  = reload;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d   = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = reload;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line level is decoded from the next state so the tx flop never glitches.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_RESET;
      state_q    <= ST_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= io.io_data_write[7:0];
  end

  always_comb begin
    io.io_data_read = 32'd0;
    case (word)
      6'd1: begin
        io.io_data_read[0]    = (state_q != ST_IDLE);
        io.io_data_read[1]    = fifo_full;
        io.io_data_read[2]    = fifo_empty;
        io.io_data_read[3]    = overflow_q;
        io.io_data_read[11:8] = 4'(count_q);
      end
      6'd2:    io.io_data_read[15:0] = div_q;
      default: io.io_data_read = 32'd0;
    endcase
  end

  assign tx      = tx_q;
  assign tx_idle = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register-map vector table, hand-written
// corner sequences, and randomized bursts checked against a frame-arithmetic model.
module tb_io_uart_tx;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } reg_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic tx_idle;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] burst_bytes [12];
  reg_vec_t   vecs [14];

  io_uart_tx_if bus ();

  io_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
    .clk     (clk),
    .reset   (reset),
    .io      (bus),
    .tx      (tx),
    .tx_idle (tx_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit busy, input bit ovf);
    logic [31:0] w;
    w       = 32'd0;
    w[0]    = busy;
    w[1]    = (cnt == DEPTH);
    w[2]    = (cnt == 0);
    w[3]    = ovf;
    w[11:8] = 4'(cnt);
    return w;
  endfunction

  // One clock edge with the given bus drive; starts and ends at a falling edge.
  task automatic bus_cycle(input logic en, input logic we, input logic [7:0] addr, input logic [31:0] data);
    bus.io_en         = en;
    bus.io_we         = we;
    bus.io_addr       = addr;
    bus.io_data_write = data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [31:0] data);
    bus.io_en   = 1'b0;
    bus.io_we   = 1'b0;
    bus.io_addr = addr;
    #1;
    data = bus.io_data_read;
  endtask

  task automatic do_reset();
    logic [31:0] rd;
    reset = 1'b1;
    bus.io_en = 1'b0;
    bus.io_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_reg(8'h04, rd);
    check("reset_status", rd, 32'h4);
  endtask

  // Writes n bytes on consecutive edges (edge 0 .. n-1) and checks tx/tx_idle every
  // cycle against the frame timeline derived from P, plus STATUS at key points.
  task automatic run_frames(input int n, input logic [15:0] div);
    int p, acc, flen, f, b;
    logic exp_tx;
    p    = (div == 16'd0) ? 1 : int'(div);
    acc  = (n > DEPTH + 1) ? DEPTH + 1 : n;
    flen = 10 * p;
    bus_cycle(1'b1, 1'b1, 8'h08, {16'h0, div});
    bus_cycle(1'b1, 1'b1, 8'h04, 32'h8);
    for (int k = 0; k < 1 + flen * acc + 3; k++) begin
      if (k < n) bus_cycle(1'b1, 1'b1, 8'h00, {24'h0, burst_bytes[k]});
      else       bus_cycle(1'b0, 1'b0, 8'h04, 32'h0);
      if (k == 0 || k - 1 >= flen * acc) begin
        exp_tx = 1'b1;
      end else begin
        f = (k - 1) / flen;
        b = ((k - 1) % flen) / p;
        exp_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : burst_bytes[f][b-1];
      end
      check($sformatf("tx k=%0d", k), tx, exp_tx);
      check($sformatf("tx_idle k=%0d", k), tx_idle, (k >= 1 + flen * acc));
      if (k == n)
        check("burst_status", bus.io_data_read, status_word(acc - 1, 1'b1, n > DEPTH + 1));
      if (k > n && k - 1 < flen * acc && ((k - 1) % flen) == 5 * p) begin
        f = (k - 1) / flen;
        check($sformatf("frame%0d_count", f), 32'(bus.io_data_read[11:8]), 32'(acc - 1 - f));
      end
    end
    check("end_status", bus.io_data_read, status_word(0, 1'b0, n > DEPTH + 1));
  endtask

  initial begin
    logic [31:0] rd;
    logic        exp_q [$];
    logic [7:0]  db;
    int          n;
    logic [15:0] dv;

    reset = 1'b1;
    bus.io_en = 1'b0;
    bus.io_we = 1'b0;
    bus.io_addr = 8'h00;
    bus.io_data_write = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_idle", tx_idle, 1'b1);
    read_reg(8'h04, rd); check("reset_status_hold", rd, 32'h4);
    read_reg(8'h08, rd); check("reset_divisor", rd, 32'd868);
    reset = 1'b0;

    // Register map vectors, applied from reset state with the FIFO empty.
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 32'h0,       8'h04, 32'h0000_0004};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 32'h0,       8'h08, 32'h0000_0364};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 32'h0,       8'h00, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 32'h0,       8'h0C, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 32'h0,       8'h05, 32'h0000_0004};
    vecs[5]  = '{1'b1, 1'b1, 8'h08, 32'hDEAD_1234, 8'h08, 32'h0000_1234};
    vecs[6]  = '{1'b1, 1'b1, 8'h0B, 32'h0000_0005, 8'h0A, 32'h0000_0005};
    vecs[7]  = '{1'b1, 1'b1, 8'h0C, 32'h0000_FFFF, 8'h08, 32'h0000_0005};
    vecs[8]  = '{1'b1, 1'b1, 8'hFC, 32'h0000_0077, 8'hFC, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 8'h04, 32'hFFFF_FFF7, 8'h04, 32'h0000_0004};
    vecs[10] = '{1'b0, 1'b1, 8'h08, 32'h0000_0009, 8'h08, 32'h0000_0005};
    vecs[11] = '{1'b1, 1'b0, 8'h08, 32'h0000_0009, 8'h08, 32'h0000_0005};
    vecs[12] = '{1'b1, 1'b1, 8'h08, 32'h0000_0000, 8'h08, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 8'h04, 32'h0000_0008, 8'h04, 32'h0000_0004};
    for (int i = 0; i < 14; i++) begin
      bus_cycle(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      read_reg(vecs[i].raddr, rd);
      check($sformatf("regvec%0d", i), rd, vecs[i].exp);
    end
    check("regvec_tx_quiet", tx, 1'b1);
    check("regvec_idle", tx_idle, 1'b1);

    // Single frame, P = 4.
    burst_bytes[0] = 8'hA5;
    run_frames(1, 16'd4);

    // Back-to-back frames, P = 2.
    burst_bytes[0] = 8'h00; burst_bytes[1] = 8'hFF; burst_bytes[2] = 8'h55;
    run_frames(3, 16'd2);

    // Divisor zero acts as one cycle per bit.
    burst_bytes[0] = 8'h3C;
    run_frames(1, 16'd0);

    // Divisor change during data bit 3: P = 8 until bit 3 ends, then P = 2.
    db = 8'hA8;
    exp_q.push_back(1'b1);
    repeat (8) exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) repeat (8) exp_q.push_back(db[i]);
    for (int i = 4; i < 8; i++) repeat (2) exp_q.push_back(db[i]);
    repeat (2) exp_q.push_back(1'b1);
    while (exp_q.size() < 56) exp_q.push_back(1'b1);
    bus_cycle(1'b1, 1'b1, 8'h08, 32'd8);
    for (int k = 0; k < 56; k++) begin
      if (k == 0)       bus_cycle(1'b1, 1'b1, 8'h00, {24'h0, db});
      else if (k == 36) bus_cycle(1'b1, 1'b1, 8'h08, 32'd2);
      else              bus_cycle(1'b0, 1'b0, 8'h04, 32'h0);
      check($sformatf("divchg tx k=%0d", k), tx, exp_q[k]);
      check($sformatf("divchg idle k=%0d", k), tx_idle, (k >= 51));
    end

    // Overflow: 10 writes with a long bit period; 9 accepted, the 10th dropped.
    bus_cycle(1'b1, 1'b1, 8'h08, 32'd1000);
    for (int k = 0; k < 10; k++) bus_cycle(1'b1, 1'b1, 8'h00, 32'(k + 16));
    read_reg(8'h04, rd); check("ovf_status", rd, status_word(8, 1'b1, 1'b1));
    bus_cycle(1'b1, 1'b1, 8'h04, 32'h8);
    read_reg(8'h04, rd); check("ovf_cleared", rd, status_word(8, 1'b1, 1'b0));
    check("ovf_start_bit", tx, 1'b0);
    do_reset();

    // A push against a full FIFO is dropped even on the edge the serialiser pops.
    bus_cycle(1'b1, 1'b1, 8'h08, 32'd2);
    for (int k = 0; k < 22; k++) begin
      if (k < 9)        bus_cycle(1'b1, 1'b1, 8'h00, 32'(k));
      else if (k == 21) bus_cycle(1'b1, 1'b1, 8'h00, 32'hEE);
      else              bus_cycle(1'b0, 1'b0, 8'h04, 32'h0);
      if (k == 20) check("full_before_pop", bus.io_data_read, status_word(8, 1'b1, 1'b0));
    end
    read_reg(8'h04, rd); check("drop_on_pop", rd, status_word(7, 1'b1, 1'b1));
    do_reset();

    // Reset asserted during data bit 4 with bytes still queued.
    bus_cycle(1'b1, 1'b1, 8'h08, 32'd4);
    for (int k = 0; k < 23; k++) begin
      if (k < 3) bus_cycle(1'b1, 1'b1, 8'h00, 32'h0F);
      else       bus_cycle(1'b0, 1'b0, 8'h04, 32'h0);
    end
    check("pre_reset_bit4", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", tx, 1'b1);
    check("async_reset_idle", tx_idle, 1'b1);
    check("async_reset_status", bus.io_data_read, 32'h4);
    @(negedge clk);
    reset = 1'b0;
    read_reg(8'h04, rd); check("post_reset_status", rd, 32'h4);
    burst_bytes[0] = 8'h96;
    run_frames(1, 16'd4);

    // Randomized bursts; long bursts use P >= 2 so the first frame outlasts the burst.
    for (int it = 0; it < 10; it++) begin
      n  = $urandom_range(1, 12);
      dv = (n > DEPTH + 1) ? 16'($urandom_range(2, 6)) : 16'($urandom_range(0, 6));
      for (int i = 0; i < 12; i++) burst_bytes[i] = 8'($urandom);
      run_frames(n, dv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
